// File: rtl/bus_decoder.sv
// Address decoder for a 16-slot bus: combinational address-phase select,
// registered data-phase select for the read-data mux, and a built-in
// default slave (slot 0) that gives a two-cycle error response to
// unmapped requests and keeps an error counter and the last error address.
module bus_decoder #(
    parameter logic [15:0] SLV_EN  = 16'hFFFE,
    parameter logic [38:0] ERR_RDT = 39'h0
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        MsREQ,
    input  logic [31:0] MsADDR,
    input  logic        MsRDY,
    input  logic        ErrClr,
    output logic [15:0] DsSEL,
    output logic [15:0] DmRMUX,
    output logic [38:0] S0RDT,
    output logic        S0RDY,
    output logic        S0ERR,
    output logic [7:0]  ErrCnt,
    output logic [31:0] ErrAddr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERR1 = 2'd1,
        ERR2 = 2'd2
    } s0_state_e;

    s0_state_e   state_q;
    logic        s0rdy_q;
    logic        s0err_q;
    logic [15:0] rmux_q, rmux_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] eaddr_q, eaddr_d;

    logic [3:0]  idx;
    logic        hit;
    logic        accept;
    logic        unmapped;
    logic        err_entry;

    assign idx       = MsADDR[31:28];
    assign hit       = (idx != 4'd0) && SLV_EN[idx];
    assign accept    = MsRDY;
    assign unmapped  = MsREQ && !hit;
    // ERR1 never starts a new response; the held request is taken in ERR2.
    assign err_entry = accept && unmapped && (state_q != ERR1);

    // Address-phase select: idle selects nothing, misses fall to slot 0.
    always_comb begin
        DsSEL = 16'h0000;
        if (MsREQ) begin
            if (hit) DsSEL[idx] = 1'b1;
            else     DsSEL      = 16'h0001;
        end
    end

    // Next-state for data-phase select and error bookkeeping.
    always_comb begin
        rmux_d  = rmux_q;
        cnt_d   = cnt_q;
        eaddr_d = eaddr_q;
        if (accept) rmux_d = MsREQ ? DsSEL : 16'h0001;
        if (err_entry) begin
            eaddr_d = MsADDR;
            if (ErrClr)              cnt_d = 8'd1;
            else if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end else if (ErrClr) begin
            cnt_d = 8'd0;
        end
    end

    // Data-phase select and error registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rmux_q  <= 16'h0001;
            cnt_q   <= 8'd0;
            eaddr_q <= 32'd0;
        end else begin
            rmux_q  <= rmux_d;
            cnt_q   <= cnt_d;
            eaddr_q <= eaddr_d;
        end
    end

    // Default-slave response FSM with registered Moore outputs, so the
    // S0RDY -> mux -> MsRDY loop always passes through a flop.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            s0rdy_q <= 1'b1;
            s0err_q <= 1'b0;
        end else begin
            case (state_q)
                ERR1: begin
                    state_q <= ERR2;
                    s0rdy_q <= 1'b1;
                    s0err_q <= 1'b1;
                end
                default: begin
                    if (accept) begin
                        if (unmapped) begin
                            state_q <= ERR1;
                            s0rdy_q <= 1'b0;
                            s0err_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            s0rdy_q <= 1'b1;
                            s0err_q <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign DmRMUX  = rmux_q;
    assign S0RDT   = ERR_RDT;
    assign S0RDY   = s0rdy_q;
    assign S0ERR   = s0err_q;
    assign ErrCnt  = cnt_q;
    assign ErrAddr = eaddr_q;

endmodule

// File: tb/tb_bus_decoder.sv
// Bench for bus_decoder: two instances (default map and SLV_EN=16'hFFF6)
// share one stimulus stream; each sees its own MsRDY as a read-data mux
// would present it (low during the first error cycle).
module tb_bus_decoder;

    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    logic        MsREQ = 1'b0;
    logic [31:0] MsADDR = 32'd0;
    logic        ErrClr = 1'b0;
    logic        rdy = 1'b1;

    logic        rdy_v  [2];
    logic [15:0] dssel  [2];
    logic [15:0] rmux   [2];
    logic [38:0] rdt    [2];
    logic        s0rdy  [2];
    logic        s0err  [2];
    logic [7:0]  ecnt   [2];
    logic [31:0] eaddr  [2];

    // Model state: rmux, error-response age (0 none, 1 first, 2 second),
    // error count and last error address.
    logic [15:0] m_rmux [2];
    int          m_age  [2];
    int          m_cnt  [2];
    logic [31:0] m_addr [2];

    int n_pass = 0;
    int n_tot  = 0;

    always #5 CLK = ~CLK;

    assign rdy_v[0] = rdy && (m_age[0] != 1);
    assign rdy_v[1] = rdy && (m_age[1] != 1);

    bus_decoder #(.SLV_EN(16'hFFFE), .ERR_RDT(39'h0)) u0 (
        .CLK(CLK), .nRST(nRST), .MsREQ(MsREQ), .MsADDR(MsADDR), .MsRDY(rdy_v[0]),
        .ErrClr(ErrClr), .DsSEL(dssel[0]), .DmRMUX(rmux[0]), .S0RDT(rdt[0]),
        .S0RDY(s0rdy[0]), .S0ERR(s0err[0]), .ErrCnt(ecnt[0]), .ErrAddr(eaddr[0]));

    bus_decoder #(.SLV_EN(16'hFFF6), .ERR_RDT(39'h55_1234_ABCD)) u1 (
        .CLK(CLK), .nRST(nRST), .MsREQ(MsREQ), .MsADDR(MsADDR), .MsRDY(rdy_v[1]),
        .ErrClr(ErrClr), .DsSEL(dssel[1]), .DmRMUX(rmux[1]), .S0RDT(rdt[1]),
        .S0RDY(s0rdy[1]), .S0ERR(s0err[1]), .ErrCnt(ecnt[1]), .ErrAddr(eaddr[1]));

    function automatic logic [15:0] slv_of(input int k);
        return (k == 0) ? 16'hFFFE : 16'hFFF6;
    endfunction

    function automatic logic [38:0] rdt_of(input int k);
        return (k == 0) ? 39'h0 : 39'h55_1234_ABCD;
    endfunction

    function automatic bit is_hit(input int k, input logic [31:0] a);
        int r;
        logic [15:0] en;
        r  = int'(a[31:28]);
        en = slv_of(k);
        return (r != 0) && (en[r] == 1'b1);
    endfunction

    function automatic logic [15:0] exp_sel(input int k, input logic req, input logic [31:0] a);
        if (!req) return 16'h0000;
        if (is_hit(k, a)) return 16'h0001 << a[31:28];
        return 16'h0001;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    endtask

    // Behavioural model, updated on the same edges as the design.
    always @(posedge CLK or negedge nRST) begin
        for (int k = 0; k < 2; k++) begin
            if (!nRST) begin
                m_rmux[k] <= 16'h0001;
                m_age[k]  <= 0;
                m_cnt[k]  <= 0;
                m_addr[k] <= 32'd0;
            end else begin
                automatic bit acc = rdy_v[k];
                automatic bit unm = MsREQ && !is_hit(k, MsADDR);
                automatic bit start = acc && unm && (m_age[k] != 1);
                if (acc) m_rmux[k] <= MsREQ ? exp_sel(k, 1'b1, MsADDR) : 16'h0001;
                if (m_age[k] == 1) m_age[k] <= 2;
                else if (acc)      m_age[k] <= unm ? 1 : 0;
                if (start) begin
                    m_addr[k] <= MsADDR;
                    m_cnt[k]  <= ErrClr ? 1 : ((m_cnt[k] + 1 > 255) ? 255 : m_cnt[k] + 1);
                end else if (ErrClr) begin
                    m_cnt[k] <= 0;
                end
            end
        end
    end

    // Per-cycle comparison of every output of both instances.
    always @(negedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("u%0d.DsSEL", k),  64'(dssel[k]), 64'(exp_sel(k, MsREQ, MsADDR)));
            chk($sformatf("u%0d.DmRMUX", k), 64'(rmux[k]),  64'(m_rmux[k]));
            chk($sformatf("u%0d.S0RDT", k),  64'(rdt[k]),   64'(rdt_of(k)));
            chk($sformatf("u%0d.S0RDY", k),  64'(s0rdy[k]), 64'(m_age[k] != 1));
            chk($sformatf("u%0d.S0ERR", k),  64'(s0err[k]), 64'(m_age[k] != 0));
            chk($sformatf("u%0d.ErrCnt", k), 64'(ecnt[k]),  64'(m_cnt[k]));
            chk($sformatf("u%0d.ErrAddr", k), 64'(eaddr[k]), 64'(m_addr[k]));
        end
    end

    // Apply inputs, then step through one rising edge.
    task automatic cyc(input logic req, input logic [31:0] a, input logic r, input logic clr);
        MsREQ  = req;
        MsADDR = a;
        rdy    = r;
        ErrClr = clr;
        @(posedge CLK);
        #2;
    endtask

    initial begin
        #1 nRST = 1'b0;
        @(posedge CLK); #2;
        chk("rst.DmRMUX", 64'(rmux[0]), 64'h0001);
        chk("rst.S0RDY",  64'(s0rdy[0]), 64'h1);
        chk("rst.S0ERR",  64'(s0err[0]), 64'h0);
        chk("rst.ErrCnt", 64'(ecnt[0]), 64'h0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        nRST = 1'b1;
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        chk("idle.DmRMUX", 64'(rmux[0]), 64'h0001);
        chk("idle.DsSEL",  64'(dssel[0]), 64'h0000);
        chk("idle.S0RDY",  64'(s0rdy[0]), 64'h1);

        // Mapped request to region 3 (unmapped for u1).
        MsREQ = 1'b1; MsADDR = 32'h3000_0010; #1;
        chk("map.DsSEL.u0", 64'(dssel[0]), 64'h0008);
        chk("map.DsSEL.u1", 64'(dssel[1]), 64'h0001);
        cyc(1'b1, 32'h3000_0010, 1'b1, 1'b0);
        chk("map.DmRMUX", 64'(rmux[0]), 64'h0008);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);

        // Region 0 request: two-cycle error response.
        cyc(1'b1, 32'h0000_0004, 1'b1, 1'b0);
        chk("err1.S0RDY", 64'(s0rdy[0]), 64'h0);
        chk("err1.S0ERR", 64'(s0err[0]), 64'h1);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        chk("err2.S0RDY",  64'(s0rdy[0]), 64'h1);
        chk("err2.S0ERR",  64'(s0err[0]), 64'h1);
        chk("err.ErrCnt",  64'(ecnt[0]), 64'h1);
        chk("err.ErrAddr", 64'(eaddr[0]), 64'h0000_0004);
        cyc(1'b0, 32'd0, 1'b1, 1'b1);
        chk("clr.ErrCnt.u1", 64'(ecnt[1]), 64'h0);

        // Back-to-back unmapped requests on u1 (region 3 disabled there).
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 32'h3000_0100 + 32'(i), 1'b1, 1'b0);
            chk("b2b.S0ERR.u1", 64'(s0err[1]), 64'h1);
            chk("b2b.S0RDY.u1", 64'(s0rdy[1]), (i % 2 == 0) ? 64'h0 : 64'h1);
        end
        chk("b2b.ErrCnt.u1", 64'(ecnt[1]), 64'h2);
        chk("b2b.DmRMUX.u0", 64'(rmux[0]), 64'h0008);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);

        // Stall: MsRDY low for 3 cycles with changing address.
        cyc(1'b1, 32'h5000_0000, 1'b1, 1'b0);
        chk("stall.pre", 64'(rmux[0]), 64'h0020);
        cyc(1'b1, 32'h0000_0000, 1'b0, 1'b0);
        cyc(1'b1, 32'h2000_0000, 1'b0, 1'b0);
        cyc(1'b1, 32'h7000_0000, 1'b0, 1'b0);
        chk("stall.DmRMUX", 64'(rmux[0]), 64'h0020);
        chk("stall.S0ERR",  64'(s0err[0]), 64'h0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);

        // Clear coincident with an error entry.
        cyc(1'b1, 32'h0ABC_0000, 1'b1, 1'b1);
        chk("clrerr.ErrCnt",  64'(ecnt[0]), 64'h1);
        chk("clrerr.ErrAddr", 64'(eaddr[0]), 64'h0ABC_0000);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);

        // Saturation: 300 back-to-back errors.
        for (int i = 0; i < 600; i++) cyc(1'b1, 32'h0000_1000, 1'b1, 1'b0);
        chk("sat.ErrCnt", 64'(ecnt[0]), 64'hFF);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        chk("sat.hold", 64'(ecnt[0]), 64'hFF);

        // Reset pulsed during ERR1.
        cyc(1'b1, 32'h0000_0008, 1'b1, 1'b0);
        chk("rerr.S0RDY", 64'(s0rdy[0]), 64'h0);
        nRST = 1'b0; #1;
        chk("rerr.DmRMUX", 64'(rmux[0]), 64'h0001);
        chk("rerr.S0ERR",  64'(s0err[0]), 64'h0);
        chk("rerr.ErrCnt", 64'(ecnt[0]), 64'h0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        nRST = 1'b1;
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        chk("rerr.post.S0RDY", 64'(s0rdy[0]), 64'h1);
        chk("rerr.post.ErrCnt", 64'(ecnt[0]), 64'h0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
